// File: rtl/des_message_generator.sv
// Plaintext block source for the pipelined DES core: on start, emits a counted run of
// 64-bit Fibonacci-LFSR blocks, one per enabled cycle, then pulses done.
module des_message_generator #(
  parameter int          CNT_W        = 32,
  parameter logic [63:0] DEFAULT_SEED = 64'h0123456789ABCDEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [63:0]      seed,
  input  logic [CNT_W-1:0] num_messages,
  input  logic             enable,
  output logic [63:0]      message,
  output logic             message_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_DONE} state_t;

  state_t           state, state_next;
  logic [63:0]      lfsr, lfsr_next;
  logic [CNT_W-1:0] remaining, remaining_next;
  logic             emit;

  // Taps 64,63,61,60: feedback enters at the LSB as the register shifts left.
  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  // After the last block GEN sees remaining==0 and spends one more cycle there,
  // which lines done up with the DONE state and keeps busy == (state != IDLE).
  always_comb begin
    state_next     = state;
    lfsr_next      = lfsr;
    remaining_next = remaining;
    emit           = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          lfsr_next      = (seed == 64'd0) ? DEFAULT_SEED : seed;
          remaining_next = num_messages;
          state_next     = S_GEN;
        end
      end
      S_GEN: begin
        if (remaining == '0) begin
          state_next = S_DONE;
        end else if (enable) begin
          emit           = 1'b1;
          lfsr_next      = lfsr_step(lfsr);
          remaining_next = remaining - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state view so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      lfsr          <= DEFAULT_SEED;
      remaining     <= '0;
      message       <= 64'd0;
      message_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_next;
      lfsr          <= lfsr_next;
      remaining     <= remaining_next;
      message_valid <= emit;
      if (emit) begin
        message <= lfsr;
      end
      busy          <= (state_next != S_IDLE);
      done          <= (state_next == S_DONE);
    end
  end

endmodule

// File: tb/tb_des_message_generator.sv
// Self-checking bench for des_message_generator: directed scenarios plus randomized runs
// compared cycle by cycle against a run-level reference model.
module tb_des_message_generator;

  localparam int          MAXC     = 63;
  localparam logic [63:0] DEF_SEED = 64'h0123456789ABCDEF;
  localparam logic [63:0] TAP_MASK = 64'hD800_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        enable = 1'b0;
  logic [63:0] seed = 64'd0;
  logic [31:0] num_messages = 32'd0;
  logic [63:0] message;
  logic        message_valid;
  logic        busy;
  logic        done;

  des_message_generator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .seed         (seed),
    .num_messages (num_messages),
    .enable       (enable),
    .message      (message),
    .message_valid(message_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [66:0] obs  [0:MAXC];
  logic [66:0] expv [0:MAXC];
  logic [63:0] last_msg = 64'd0;

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    return (s << 1) | {63'd0, ^(s & TAP_MASK)};
  endfunction

  // Expected {busy,done,valid,message} per cycle, cycle 0 being the start cycle.
  // Blocks are emitted in the cycle after each enabled GEN cycle; done lands two
  // cycles after the last emitting cycle and busy covers cycles 1..done.
  task automatic model_run(input logic [63:0] sd, input logic [31:0] n,
                           input logic [MAXC:0] en_in, output logic [MAXC:0] en_out,
                           output int ncyc);
    logic [63:0]   s, msg;
    logic [MAXC:0] emit_at;
    logic [32:0]   cnt;
    int            c, c_last, d;
    s = (sd == 64'd0) ? DEF_SEED : sd;
    msg = last_msg;
    emit_at = '0;
    cnt = 33'd0;
    c_last = 0;
    en_out = en_in;
    c = 1;
    while (cnt < {1'b0, n} && c < MAXC) begin
      if (c >= 40) en_out[c] = 1'b1;
      if (en_out[c]) begin
        emit_at[c] = 1'b1;
        cnt = cnt + 33'd1;
        c_last = c;
      end
      c++;
    end
    for (int k = c_last + 1; k <= MAXC; k++) en_out[k] = 1'b1;
    d = c_last + 2;
    ncyc = (d + 2 > MAXC) ? MAXC : d + 2;
    for (int k = 0; k <= MAXC; k++) begin
      logic v;
      v = (k >= 1) ? emit_at[k-1] : 1'b0;
      if (v) begin
        msg = s;
        s = lfsr_next(s);
      end
      expv[k] = {(k >= 1 && k <= d), (k == d), v, msg};
    end
    last_msg = msg;
  endtask

  task automatic drive_run(input logic [63:0] sd, input logic [31:0] n,
                           input logic [MAXC:0] en, input int ncyc,
                           input int mid_start_c, input int rst_c);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      start        = (c == 0) || (c == mid_start_c);
      seed         = (c == 0) ? sd : {$urandom, $urandom};
      num_messages = (c == 0) ? n : $urandom_range(1, 8);
      enable       = en[c];
      rst_n        = (c != rst_c);
      @(negedge clk);
      obs[c] = {busy, done, message_valid, message};
    end
  endtask

  task automatic test_reset();
    logic [MAXC:0] en;
    int ncyc;
    rst_n = 1'b0; start = 1'b0; enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, message_valid, message} !== 67'd0)
      $display("[TB] FAIL reset_outputs: got %h, expected 0", {busy, done, message_valid, message});
    else n_pass++;
    last_msg = 64'd0;
    model_run(64'd0, 32'd1, '1, en, ncyc);
    drive_run(64'd0, 32'd1, en, ncyc, -1, -1);
    for (int c = 0; c < ncyc; c++) begin
      n_checks++;
      if (obs[c] !== expv[c])
        $display("[TB] FAIL reset_seed0 t+%0d: got %h, expected %h ({busy,done,valid,message})", c, obs[c], expv[c]);
      else n_pass++;
    end
    n_checks++;
    if (obs[2][64:0] !== {1'b1, DEF_SEED})
      $display("[TB] FAIL default_seed_block: got %h, expected %h", obs[2][64:0], {1'b1, DEF_SEED});
    else n_pass++;
    n_checks++;
    if (obs[3][65] !== 1'b1) $display("[TB] FAIL default_seed_done: got %b, expected 1", obs[3][65]);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [MAXC:0] en;
    int ncyc;
    logic [63:0] blocks [0:3];
    blocks[0] = 64'h1; blocks[1] = 64'h2; blocks[2] = 64'h4; blocks[3] = 64'h8;
    model_run(64'h1, 32'd4, '1, en, ncyc);
    drive_run(64'h1, 32'd4, en, ncyc, -1, -1);
    for (int c = 0; c < ncyc; c++) begin
      n_checks++;
      if (obs[c] !== expv[c])
        $display("[TB] FAIL basic_trace t+%0d: got %h, expected %h ({busy,done,valid,message})", c, obs[c], expv[c]);
      else n_pass++;
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (obs[k+2][64:0] !== {1'b1, blocks[k]})
        $display("[TB] FAIL basic_block%0d: got %h, expected %h", k, obs[k+2][64:0], {1'b1, blocks[k]});
      else n_pass++;
    end
    n_checks++;
    if (obs[6][66:64] !== 3'b110 || obs[7][66] !== 1'b0)
      $display("[TB] FAIL basic_done_busy: got t+6=%b t+7 busy=%b, expected 110 and 0", obs[6][66:64], obs[7][66]);
    else n_pass++;
  endtask

  task automatic test_feedback();
    logic [MAXC:0] en;
    int ncyc;
    logic [63:0] blocks [0:2];
    blocks[0] = 64'h8000000000000000; blocks[1] = 64'h1; blocks[2] = 64'h2;
    model_run(64'h8000000000000000, 32'd3, '1, en, ncyc);
    drive_run(64'h8000000000000000, 32'd3, en, ncyc, -1, -1);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (obs[k+2][64:0] !== {1'b1, blocks[k]})
        $display("[TB] FAIL feedback_block%0d: got %h, expected %h", k, obs[k+2][64:0], {1'b1, blocks[k]});
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    logic [MAXC:0] en;
    int ncyc;
    model_run(64'h1, 32'd3, ~64'b1100, en, ncyc);
    drive_run(64'h1, 32'd3, en, ncyc, -1, -1);
    for (int c = 0; c < ncyc; c++) begin
      n_checks++;
      if (obs[c] !== expv[c])
        $display("[TB] FAIL stall_trace t+%0d: got %h, expected %h ({busy,done,valid,message})", c, obs[c], expv[c]);
      else n_pass++;
    end
    n_checks++;
    if (obs[3][64:0] !== {1'b0, 64'h1} || obs[4][64:0] !== {1'b0, 64'h1})
      $display("[TB] FAIL stall_hold: got %h %h, expected %h", obs[3][64:0], obs[4][64:0], {1'b0, 64'h1});
    else n_pass++;
    n_checks++;
    if (obs[5][64:0] !== {1'b1, 64'h2} || obs[6][64:0] !== {1'b1, 64'h4} || obs[7][65] !== 1'b1)
      $display("[TB] FAIL stall_resume: got %h %h done=%b, expected 1_2 1_4 done=1", obs[5][64:0], obs[6][64:0], obs[7][65]);
    else n_pass++;
  endtask

  task automatic test_zero_count();
    logic [MAXC:0] en;
    int ncyc;
    logic [63:0] sd;
    sd = {$urandom, $urandom};
    model_run(sd, 32'd0, '1, en, ncyc);
    drive_run(sd, 32'd0, en, ncyc, -1, -1);
    for (int c = 0; c < ncyc; c++) begin
      n_checks++;
      if (obs[c] !== expv[c])
        $display("[TB] FAIL zero_trace t+%0d: got %h, expected %h ({busy,done,valid,message})", c, obs[c], expv[c]);
      else n_pass++;
    end
    n_checks++;
    if (obs[1][66:64] !== 3'b100 || obs[2][66:64] !== 3'b110 || obs[3][66:64] !== 3'b000)
      $display("[TB] FAIL zero_flags: got %b %b %b, expected 100 110 000", obs[1][66:64], obs[2][66:64], obs[3][66:64]);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    logic [MAXC:0] en;
    int ncyc, nvalid;
    logic [63:0] sd;
    sd = {$urandom, $urandom};
    model_run(sd, 32'd5, '1, en, ncyc);
    drive_run(sd, 32'd5, en, ncyc, 3, -1);
    nvalid = 0;
    for (int c = 0; c < ncyc; c++) begin
      nvalid += int'(obs[c][64]);
      n_checks++;
      if (obs[c] !== expv[c])
        $display("[TB] FAIL start_ignored t+%0d: got %h, expected %h ({busy,done,valid,message})", c, obs[c], expv[c]);
      else n_pass++;
    end
    n_checks++;
    if (nvalid != 5) $display("[TB] FAIL start_ignored_count: got %0d, expected 5", nvalid);
    else n_pass++;
  endtask

  task automatic test_max_count();
    logic [MAXC:0] en;
    int ncyc;
    logic [63:0] sd;
    sd = {$urandom, $urandom};
    model_run(sd, 32'hFFFF_FFFF, '1, en, ncyc);
    drive_run(sd, 32'hFFFF_FFFF, en, 12, -1, -1);
    for (int c = 0; c < 12; c++) begin
      n_checks++;
      if (obs[c] !== expv[c])
        $display("[TB] FAIL max_count t+%0d: got %h, expected %h ({busy,done,valid,message})", c, obs[c], expv[c]);
      else n_pass++;
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    last_msg = 64'd0;
    n_checks++;
    if ({busy, done, message_valid, message} !== 67'd0)
      $display("[TB] FAIL max_count_reset: got %h, expected 0", {busy, done, message_valid, message});
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    logic [MAXC:0] en;
    int ncyc;
    model_run(64'h1, 32'd10, '1, en, ncyc);
    for (int k = 6; k <= MAXC; k++) expv[k] = 67'd0;
    drive_run(64'h1, 32'd10, en, 20, -1, 5);
    last_msg = 64'd0;
    for (int c = 0; c < 20; c++) begin
      n_checks++;
      if (obs[c] !== expv[c])
        $display("[TB] FAIL reset_mid_run t+%0d: got %h, expected %h ({busy,done,valid,message})", c, obs[c], expv[c]);
      else n_pass++;
    end
    model_run(64'h1, 32'd4, '1, en, ncyc);
    drive_run(64'h1, 32'd4, en, ncyc, -1, -1);
    for (int c = 0; c < ncyc; c++) begin
      n_checks++;
      if (obs[c] !== expv[c])
        $display("[TB] FAIL after_reset_run t+%0d: got %h, expected %h ({busy,done,valid,message})", c, obs[c], expv[c]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [MAXC:0] en;
    int ncyc;
    logic [63:0] sd;
    logic [31:0] n;
    for (int r = 0; r < 4; r++) begin
      sd = {$urandom, $urandom};
      n = $urandom_range(1, 6);
      model_run(sd, n, '1, en, ncyc);
      // Stop one cycle early so the next start lands on the first idle cycle.
      drive_run(sd, n, en, ncyc - 1, -1, -1);
      for (int c = 0; c < ncyc - 1; c++) begin
        n_checks++;
        if (obs[c] !== expv[c])
          $display("[TB] FAIL back_to_back run%0d t+%0d: got %h, expected %h", r, c, obs[c], expv[c]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [MAXC:0] en, en_fixed;
    int ncyc;
    logic [63:0] sd;
    logic [31:0] n;
    for (int r = 0; r < 20; r++) begin
      sd = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
      n = $urandom_range(0, 12);
      for (int c = 0; c <= MAXC; c++) en[c] = ($urandom_range(0, 9) < 7);
      model_run(sd, n, en, en_fixed, ncyc);
      drive_run(sd, n, en_fixed, ncyc, -1, -1);
      for (int c = 0; c < ncyc; c++) begin
        n_checks++;
        if (obs[c] !== expv[c])
          $display("[TB] FAIL random run%0d t+%0d: got %h, expected %h", r, c, obs[c], expv[c]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_feedback();
    test_stall();
    test_zero_count();
    test_start_ignored();
    test_max_count();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
